ptw_req_arbiter: RTL and testbench
==================================

Name: ptw_req_arbiter

Overview:
- Arbitrates the single shared page-table walker (PTW) between two requesters: instruction fetch (IF) and the MEM stage.
- Returns the translated address and page-fault status to the winning requester. This status feeds the `page_fault` inputs of the IF and MEM exception examiners.
- Handles pipeline flushes by cancelling a walk before issue, or dropping its response.
- One walk is outstanding at a time.

Parameters:
- STARVE_LIMIT, 4: number of consecutive MEM grants made while IF is waiting, after which IF is forced to win.
- CNT_W, 3: width of the starvation counter. Must satisfy 2^CNT_W > STARVE_LIMIT.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset.
- priv  in  2  current privilege level, forwarded with each walk.
- if_req_valid  in  1  IF translation request.
- if_req_vaddr  in  64  IF virtual address.
- if_req_ready  out  1  IF request accepted this cycle.
- if_flush  in  1  cancel any IF walk.
- if_resp_valid  out  1  one-cycle pulse; IF result valid.
- if_resp_paddr  out  64  IF physical address.
- if_resp_fault  out  1  IF page fault.
- mem_req_valid  in  1  MEM translation request.
- mem_req_vaddr  in  64  MEM virtual address.
- mem_req_we  in  1  store access.
- mem_req_re  in  1  load access.
- mem_req_ready  out  1  MEM request accepted this cycle.
- mem_flush  in  1  cancel any MEM walk.
- mem_resp_valid  out  1  one-cycle pulse; MEM result valid.
- mem_resp_paddr  out  64  MEM physical address.
- mem_resp_fault  out  1  MEM page fault.
- ptw_req_valid  out  1  walk request to the PTW.
- ptw_req_ready  in  1  PTW accepts the request.
- ptw_req_vaddr  out  64  latched virtual address.
- ptw_req_acc  out  2  access type: 0 = fetch, 1 = load, 2 = store.
- ptw_req_priv  out  2  latched privilege level.
- ptw_resp_valid  in  1  PTW result valid (single-cycle).
- ptw_resp_paddr  in  64  PTW physical address.
- ptw_resp_fault  in  1  PTW fault.

Behaviour:
- Reset (rst = 0 at a clock edge):
  - State returns to IDLE; the starvation counter clears.
  - All outputs go to 0, including both resp_valid outputs, ptw_req_valid and all latched fields.
  - Reset overrides any in-flight walk. A late ptw_resp_valid arriving after reset is ignored, because the block is in IDLE.
- States: IDLE, ISSUE, WAIT, DROP. A registered owner bit records the winner (0 = IF, 1 = MEM).
- Grant in IDLE (combinational):
  - Default: MEM wins when both requesters are valid.
  - IF wins when `starve_cnt == STARVE_LIMIT` and both are valid.
  - A lone valid requester always wins.
- Ready and flush gating:
  - `x_req_ready = (state == IDLE) & grant_x & ~x_flush`.
  - A flushed requester is never accepted in that cycle; the other requester may win instead.
- Handshake (`valid & ready`): go to ISSUE next cycle and latch the following:
  - vaddr and priv.
  - acc: IF gives 0; MEM gives 2 if we = 1, otherwise 1. If both we and re are set, store wins.
  - owner bit.
- Starvation counter:
  - On a MEM grant while `if_req_valid = 1`: increment, saturating at STARVE_LIMIT.
  - On any IF grant: clear to 0.
  - Otherwise: hold.
- ISSUE:
  - ptw_req_valid is 1, and the ptw_req_* fields stay stable until ptw_req_ready.
  - `ptw_req_ready = 1`: go to WAIT.
  - Owner's flush asserted and PTW has not accepted: go to IDLE, no response.
  - Owner's flush in the same cycle as ptw_req_ready: go to DROP.
- WAIT:
  - ptw_req_valid is 0.
  - On ptw_resp_valid with no owner flush: go to IDLE. The next cycle, pulse the owner's resp_valid for exactly 1 cycle with the registered paddr and fault.
  - Owner's flush without a response: go to DROP.
  - Owner's flush in the same cycle as ptw_resp_valid: the response is discarded and the block goes to IDLE.
- DROP: wait for ptw_resp_valid, discard it, go to IDLE. No resp_valid is produced.
- Flush of the non-owner requester has no effect on an in-flight walk.
- Latency: accept at cycle N, ISSUE at N+1. With ptw_req_ready = 1 at N+1 and ptw_resp_valid at N+1+k, resp_valid is seen at N+2+k.
- resp_paddr and resp_fault hold their last value between pulses. They are meaningful only when resp_valid = 1.
- The block accepts no new request until it is back in IDLE.
  - A resp_valid pulse and the next ready can coincide, because the block is in IDLE during the pulse cycle.

Test Plan:
- IF-only request: vaddr=0x1000, PTW ready immediately, response at +3 with paddr 0x8000_1000, fault=0 → if_resp_valid pulses once with paddr 0x8000_1000; ptw_req_acc=0; mem_resp_valid stays 0.
- Both valid, starve_cnt=0: MEM wins with we=1, acc=2. Hold both valid across 4 MEM walks → the 5th grant goes to IF and starve_cnt returns to 0.
- mem_flush during WAIT, then ptw_resp_valid 2 cycles later → no mem_resp_valid; the state passes through DROP to IDLE; the next request is accepted the cycle after the discarded response.
- if_flush during ISSUE with ptw_req_ready=0 → back to IDLE next cycle; ptw_req_valid drops; no response; PTW sees no handshake.
- ptw_resp_fault=1 for a MEM load at vaddr 0xdead_0000 → mem_resp_valid=1, mem_resp_fault=1 for one cycle; the page-fault path is observable at the MEM examiner.
- rst=0 asserted in WAIT, released, then a stray ptw_resp_valid → all outputs 0; no resp_valid; the block stays in IDLE and accepts a new IF request normally.

Source files
------------

// File: rtl/ptw_req_arbiter_if.sv
// Signal bundle between the IF/MEM requesters, the PTW arbiter and the page-table walker.
// valid/ready: a request transfers on any rising edge where both are high; resp_valid is a one-cycle pulse with no back-pressure.
interface ptw_req_arbiter_if;
    logic [1:0]  priv;
    logic        if_req_valid;
    logic [63:0] if_req_vaddr;
    logic        if_req_ready;
    logic        if_flush;
    logic        if_resp_valid;
    logic [63:0] if_resp_paddr;
    logic        if_resp_fault;
    logic        mem_req_valid;
    logic [63:0] mem_req_vaddr;
    logic        mem_req_we;
    logic        mem_req_re;
    logic        mem_req_ready;
    logic        mem_flush;
    logic        mem_resp_valid;
    logic [63:0] mem_resp_paddr;
    logic        mem_resp_fault;
    logic        ptw_req_valid;
    logic        ptw_req_ready;
    logic [63:0] ptw_req_vaddr;
    logic [1:0]  ptw_req_acc;
    logic [1:0]  ptw_req_priv;
    logic        ptw_resp_valid;
    logic [63:0] ptw_resp_paddr;
    logic        ptw_resp_fault;

    modport slave (
        input  priv, if_req_valid, if_req_vaddr, if_flush,
               mem_req_valid, mem_req_vaddr, mem_req_we, mem_req_re, mem_flush,
               ptw_req_ready, ptw_resp_valid, ptw_resp_paddr, ptw_resp_fault,
        output if_req_ready, if_resp_valid, if_resp_paddr, if_resp_fault,
               mem_req_ready, mem_resp_valid, mem_resp_paddr, mem_resp_fault,
               ptw_req_valid, ptw_req_vaddr, ptw_req_acc, ptw_req_priv
    );

    modport master (
        output priv, if_req_valid, if_req_vaddr, if_flush,
               mem_req_valid, mem_req_vaddr, mem_req_we, mem_req_re, mem_flush,
               ptw_req_ready, ptw_resp_valid, ptw_resp_paddr, ptw_resp_fault,
        input  if_req_ready, if_resp_valid, if_resp_paddr, if_resp_fault,
               mem_req_ready, mem_resp_valid, mem_resp_paddr, mem_resp_fault,
               ptw_req_valid, ptw_req_vaddr, ptw_req_acc, ptw_req_priv
    );
endinterface

// File: rtl/ptw_req_arbiter.sv
// Shares one page-table walker between IF and MEM: MEM-priority arbitration with IF starvation
// relief, one outstanding walk, and flush handling that cancels or drops the owner's walk.
module ptw_req_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic               clk,
    input  logic               rst,
    ptw_req_arbiter_if.slave   bus,
    output logic [1:0]         dbg_state_o
);
    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, DROP = 2'd3} state_e;

    localparam logic [CNT_W-1:0] LIMIT     = CNT_W'(STARVE_LIMIT);
    localparam logic [1:0]       ACC_FETCH = 2'd0;
    localparam logic [1:0]       ACC_LOAD  = 2'd1;
    localparam logic [1:0]       ACC_STORE = 2'd2;

    state_e           state_q, state_d;
    logic             owner_q, owner_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [63:0]      vaddr_q, vaddr_d;
    logic [1:0]       acc_q, acc_d;
    logic [1:0]       priv_q, priv_d;
    logic [63:0]      paddr_q, paddr_d;
    logic             fault_q, fault_d;
    logic             if_rv_q, if_rv_d;
    logic             mem_rv_q, mem_rv_d;

    logic if_ok, mem_ok, grant_if, grant_mem, if_rdy, mem_rdy, own_flush;

    // A flushed requester drops out of arbitration, so the other one can win that cycle.
    always_comb begin
        if_ok     = bus.if_req_valid & ~bus.if_flush;
        mem_ok    = bus.mem_req_valid & ~bus.mem_flush;
        grant_if  = if_ok & (~mem_ok | (cnt_q == LIMIT));
        grant_mem = mem_ok & ~grant_if;
        if_rdy    = (state_q == IDLE) & grant_if;
        mem_rdy   = (state_q == IDLE) & grant_mem;
        own_flush = owner_q ? bus.mem_flush : bus.if_flush;
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        cnt_d    = cnt_q;
        vaddr_d  = vaddr_q;
        acc_d    = acc_q;
        priv_d   = priv_q;
        paddr_d  = paddr_q;
        fault_d  = fault_q;
        if_rv_d  = 1'b0;
        mem_rv_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (if_rdy) begin
                    state_d = ISSUE;
                    owner_d = 1'b0;
                    vaddr_d = bus.if_req_vaddr;
                    acc_d   = ACC_FETCH;
                    priv_d  = bus.priv;
                    cnt_d   = '0;
                end else if (mem_rdy) begin
                    state_d = ISSUE;
                    owner_d = 1'b1;
                    vaddr_d = bus.mem_req_vaddr;
                    acc_d   = bus.mem_req_we ? ACC_STORE : ACC_LOAD;
                    priv_d  = bus.priv;
                    if (bus.if_req_valid && (cnt_q != LIMIT)) cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ISSUE: begin
                if (own_flush) state_d = bus.ptw_req_ready ? DROP : IDLE;
                else if (bus.ptw_req_ready) state_d = WAIT;
            end
            WAIT: begin
                if (bus.ptw_resp_valid) begin
                    state_d = IDLE;
                    if (!own_flush) begin
                        paddr_d  = bus.ptw_resp_paddr;
                        fault_d  = bus.ptw_resp_fault;
                        if_rv_d  = ~owner_q;
                        mem_rv_d = owner_q;
                    end
                end else if (own_flush) begin
                    state_d = DROP;
                end
            end
            DROP: begin
                if (bus.ptw_resp_valid) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            cnt_q    <= '0;
            vaddr_q  <= '0;
            acc_q    <= '0;
            priv_q   <= '0;
            paddr_q  <= '0;
            fault_q  <= 1'b0;
            if_rv_q  <= 1'b0;
            mem_rv_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            cnt_q    <= cnt_d;
            vaddr_q  <= vaddr_d;
            acc_q    <= acc_d;
            priv_q   <= priv_d;
            paddr_q  <= paddr_d;
            fault_q  <= fault_d;
            if_rv_q  <= if_rv_d;
            mem_rv_q <= mem_rv_d;
        end
    end

    assign bus.if_req_ready   = if_rdy;
    assign bus.mem_req_ready  = mem_rdy;
    assign bus.ptw_req_valid  = (state_q == ISSUE);
    assign bus.ptw_req_vaddr  = vaddr_q;
    assign bus.ptw_req_acc    = acc_q;
    assign bus.ptw_req_priv   = priv_q;
    assign bus.if_resp_valid  = if_rv_q;
    assign bus.if_resp_paddr  = paddr_q;
    assign bus.if_resp_fault  = fault_q;
    assign bus.mem_resp_valid = mem_rv_q;
    assign bus.mem_resp_paddr = paddr_q;
    assign bus.mem_resp_fault = fault_q;
    assign dbg_state_o        = state_q;
endmodule

// File: tb/tb_ptw_req_arbiter.sv
// Bench for ptw_req_arbiter: directed scenarios plus random traffic, checked by a flag-based
// walk model feeding expected queues that a negedge monitor drains.
module tb_ptw_req_arbiter;
    localparam int LIMIT = 4;

    logic       clk;
    logic       rst;
    logic [1:0] dbg_state;

    ptw_req_arbiter_if bus ();

    ptw_req_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: unexpected event", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- PTW responder ----------------
    int rdy_pct    = 100;
    int dly_lo     = 1;
    int dly_hi     = 1;
    bit fix_en     = 1'b0;
    logic [63:0] fix_paddr = '0;
    bit fix_fault  = 1'b0;
    int stray_cnt  = 0;

    initial begin
        bit hs;
        bit rst_seen;
        int wait_n;
        int stray_done;
        wait_n = 0;
        stray_done = 0;
        bus.ptw_req_ready  = 1'b0;
        bus.ptw_resp_valid = 1'b0;
        bus.ptw_resp_paddr = '0;
        bus.ptw_resp_fault = 1'b0;
        forever begin
            @(negedge clk);
            hs       = bus.ptw_req_valid && bus.ptw_req_ready;
            rst_seen = !rst;
            @(posedge clk);
            #1;
            bus.ptw_resp_valid = 1'b0;
            if (rst_seen) wait_n = 0;
            else if (hs) wait_n = $urandom_range(dly_hi, dly_lo);
            if (wait_n != 0) begin
                wait_n--;
                if (wait_n == 0) begin
                    bus.ptw_resp_valid = 1'b1;
                    bus.ptw_resp_paddr = fix_en ? fix_paddr : {$urandom, $urandom};
                    bus.ptw_resp_fault = fix_en ? fix_fault : ($urandom_range(0, 3) == 0);
                end
            end
            if (stray_cnt != stray_done) begin
                bus.ptw_resp_valid = 1'b1;
                bus.ptw_resp_paddr = {$urandom, $urandom};
                bus.ptw_resp_fault = 1'b1;
                stray_done++;
            end
            bus.ptw_req_ready = ($urandom_range(0, 99) < rdy_pct);
        end
    end

    // ---------------- scoreboard queues ----------------
    logic [67:0] ptw_q[$];   // {vaddr, acc, priv}
    logic [64:0] if_q[$];    // {paddr, fault}
    logic [64:0] mem_q[$];
    logic        obs_if_rdy  = 1'b0;
    logic        obs_mem_rdy = 1'b0;

    // ---------------- reference model ----------------
    // One walk at a time: busy until its response (or cancellation); a flush by the owner
    // cancels it, which either withdraws the PTW request or discards the PTW answer.
    bit m_busy = 1'b0, m_owner_mem = 1'b0, m_ptw_took = 1'b0, m_cancel = 1'b0;
    int m_starve = 0;

    always @(posedge clk) begin
        bit e_if, e_mem, w_if, w_mem, fl;
        logic [67:0] dropped;
        logic [1:0] acc;
        if (!rst) begin
            m_busy   = 1'b0;
            m_starve = 0;
        end else if (!m_busy) begin
            e_if  = bus.if_req_valid && !bus.if_flush;
            e_mem = bus.mem_req_valid && !bus.mem_flush;
            w_if  = e_if && (!e_mem || m_starve == LIMIT);
            w_mem = e_mem && !w_if;
            check("if_req_ready", {67'd0, obs_if_rdy}, {67'd0, w_if});
            check("mem_req_ready", {67'd0, obs_mem_rdy}, {67'd0, w_mem});
            if (w_if || w_mem) begin
                acc = w_if ? 2'd0 : (bus.mem_req_we ? 2'd2 : 2'd1);
                ptw_q.push_back({w_if ? bus.if_req_vaddr : bus.mem_req_vaddr, acc, bus.priv});
                m_busy      = 1'b1;
                m_owner_mem = w_mem;
                m_ptw_took  = 1'b0;
                m_cancel    = 1'b0;
                if (w_if) m_starve = 0;
                else if (bus.if_req_valid && m_starve < LIMIT) m_starve++;
            end
        end else begin
            check("ready_while_busy", {66'd0, obs_if_rdy, obs_mem_rdy}, 68'd0);
            fl = m_owner_mem ? bus.mem_flush : bus.if_flush;
            if (!m_ptw_took) begin
                if (bus.ptw_req_ready) begin
                    m_ptw_took = 1'b1;
                    m_cancel   = fl;
                end else if (fl) begin
                    m_busy  = 1'b0;
                    dropped = ptw_q.pop_back();
                end
            end else if (bus.ptw_resp_valid) begin
                m_busy = 1'b0;
                if (!(m_cancel || fl)) begin
                    if (m_owner_mem) mem_q.push_back({bus.ptw_resp_paddr, bus.ptw_resp_fault});
                    else if_q.push_back({bus.ptw_resp_paddr, bus.ptw_resp_fault});
                end
            end else if (fl) begin
                m_cancel = 1'b1;
            end
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [67:0] e;
        logic [64:0] r;
        obs_if_rdy  = bus.if_req_ready;
        obs_mem_rdy = bus.mem_req_ready;
        if (rst) begin
            if (bus.ptw_req_valid && bus.ptw_req_ready) begin
                if (ptw_q.size() == 0) fail_now("ptw_req_unexpected");
                else begin
                    e = ptw_q.pop_front();
                    check("ptw_req_fields", {bus.ptw_req_vaddr, bus.ptw_req_acc, bus.ptw_req_priv}, e);
                end
            end
            if (bus.if_resp_valid) begin
                if (if_q.size() == 0) fail_now("if_resp_unexpected");
                else begin
                    r = if_q.pop_front();
                    check("if_resp", {3'd0, bus.if_resp_paddr, bus.if_resp_fault}, {3'd0, r});
                end
            end
            if (bus.mem_resp_valid) begin
                if (mem_q.size() == 0) fail_now("mem_resp_unexpected");
                else begin
                    r = mem_q.pop_front();
                    check("mem_resp", {3'd0, bus.mem_resp_paddr, bus.mem_resp_fault}, {3'd0, r});
                end
            end
        end
    end

    // ---------------- driver / directed scenarios ----------------
    task automatic idle_inputs();
        bus.if_req_valid  = 1'b0;
        bus.mem_req_valid = 1'b0;
        bus.if_flush      = 1'b0;
        bus.mem_flush     = 1'b0;
        bus.mem_req_we    = 1'b0;
        bus.mem_req_re    = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        idle_inputs();
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int lat, npulse, nother, n_hs;
        logic [1:0] acc_seen;
        logic [63:0] paddr_seen;
        logic fault_seen;
        int acc_seq[6];

        rst = 1'b0;
        bus.priv = 2'd0;
        bus.if_req_vaddr  = '0;
        bus.mem_req_vaddr = '0;
        idle_inputs();
        repeat (3) tick();
        @(negedge clk);
        check("reset_outputs",
              {bus.ptw_req_valid, bus.if_resp_valid, bus.mem_resp_valid, bus.if_req_ready,
               bus.mem_req_ready, bus.ptw_req_acc, bus.ptw_req_priv, dbg_state, 57'd0},
              68'd0);
        check("reset_vaddr", {4'd0, bus.ptw_req_vaddr}, 68'd0);
        rst = 1'b1;
        tick();

        // IF-only walk, PTW ready at once, answer 3 cycles after issue.
        fix_en = 1'b1; fix_paddr = 64'h8000_1000; fix_fault = 1'b0;
        rdy_pct = 100; dly_lo = 3; dly_hi = 3;
        idle_cycles(2);
        bus.priv = 2'd1;
        bus.if_req_valid = 1'b1;
        bus.if_req_vaddr = 64'h1000;
        @(negedge clk);
        check("t1_if_ready", {67'd0, bus.if_req_ready}, 68'd1);
        tick();
        bus.if_req_valid = 1'b0;
        lat = 0; npulse = 0; nother = 0; acc_seen = 2'd3; paddr_seen = '0;
        for (int j = 1; j <= 20; j++) begin
            @(negedge clk);
            if (bus.ptw_req_valid && bus.ptw_req_ready) acc_seen = bus.ptw_req_acc;
            if (bus.if_resp_valid) begin
                if (lat == 0) begin lat = j; paddr_seen = bus.if_resp_paddr; end
                npulse++;
            end
            if (bus.mem_resp_valid) nother++;
            tick();
        end
        check("t1_latency", 68'(lat), 68'd5);
        check("t1_pulses", 68'(npulse), 68'd1);
        check("t1_paddr", {4'd0, paddr_seen}, {4'd0, 64'h8000_1000});
        check("t1_acc", {66'd0, acc_seen}, 68'd0);
        check("t1_no_mem_resp", 68'(nother), 68'd0);

        // Both requesters held valid: four MEM stores, then IF forced, then MEM again.
        fix_en = 1'b0; dly_lo = 1; dly_hi = 1;
        idle_cycles(2);
        bus.if_req_valid  = 1'b1; bus.if_req_vaddr  = 64'h0000_0000_0040_0000;
        bus.mem_req_valid = 1'b1; bus.mem_req_vaddr = 64'h0000_0000_0080_0000;
        bus.mem_req_we = 1'b1; bus.mem_req_re = 1'b0;
        n_hs = 0;
        for (int j = 0; j < 80 && n_hs < 6; j++) begin
            @(negedge clk);
            if (bus.ptw_req_valid && bus.ptw_req_ready) begin
                acc_seq[n_hs] = int'(bus.ptw_req_acc);
                n_hs++;
            end
            tick();
        end
        idle_cycles(10);
        check("t2_grants", 68'(n_hs), 68'd6);
        for (int k = 0; k < 4; k++) check("t2_mem_first", 68'(acc_seq[k]), 68'd2);
        check("t2_if_forced", 68'(acc_seq[4]), 68'd0);
        check("t2_cnt_cleared", 68'(acc_seq[5]), 68'd2);

        // mem_flush while waiting; the late answer is dropped.
        dly_lo = 4; dly_hi = 4;
        idle_cycles(2);
        nother = 0;
        bus.mem_req_valid = 1'b1; bus.mem_req_vaddr = 64'h2000; bus.mem_req_re = 1'b1;
        tick();                                         // N+1
        bus.mem_req_valid = 1'b0;
        tick();                                         // N+2
        tick();                                         // N+3
        bus.mem_flush = 1'b1;
        @(negedge clk);
        check("t3_wait", {66'd0, dbg_state}, 68'd2);
        tick();                                         // N+4
        bus.mem_flush = 1'b0;
        @(negedge clk);
        if (bus.mem_resp_valid) nother++;
        check("t3_drop", {66'd0, dbg_state}, 68'd3);
        tick();                                         // N+5
        bus.mem_req_valid = 1'b1; bus.mem_req_vaddr = 64'h3000;
        @(negedge clk);
        if (bus.mem_resp_valid) nother++;
        check("t3_busy", {67'd0, bus.mem_req_ready}, 68'd0);
        tick();                                         // N+6
        @(negedge clk);
        if (bus.mem_resp_valid) nother++;
        check("t3_accept_after_drop", {67'd0, bus.mem_req_ready}, 68'd1);
        check("t3_no_mem_resp", 68'(nother), 68'd0);
        tick();
        bus.mem_req_valid = 1'b0;
        idle_cycles(10);

        // if_flush while issuing, PTW never ready.
        rdy_pct = 0; dly_lo = 1; dly_hi = 1;
        idle_cycles(2);
        bus.if_req_valid = 1'b1; bus.if_req_vaddr = 64'h4000;
        tick();
        bus.if_req_valid = 1'b0; bus.if_flush = 1'b1;
        @(negedge clk);
        check("t4_issue", {67'd0, bus.ptw_req_valid}, 68'd1);
        tick();
        bus.if_flush = 1'b0;
        @(negedge clk);
        check("t4_cancelled", {65'd0, bus.ptw_req_valid, dbg_state}, 68'd0);
        rdy_pct = 100;
        idle_cycles(4);

        // MEM load that faults.
        fix_en = 1'b1; fix_paddr = 64'h1234_5000; fix_fault = 1'b1; dly_lo = 2; dly_hi = 2;
        idle_cycles(2);
        bus.mem_req_valid = 1'b1; bus.mem_req_vaddr = 64'hdead_0000;
        bus.mem_req_we = 1'b0; bus.mem_req_re = 1'b1;
        tick();
        bus.mem_req_valid = 1'b0;
        npulse = 0; fault_seen = 1'b0; acc_seen = 2'd3;
        for (int j = 0; j < 15; j++) begin
            @(negedge clk);
            if (bus.ptw_req_valid && bus.ptw_req_ready) acc_seen = bus.ptw_req_acc;
            if (bus.mem_resp_valid) begin npulse++; fault_seen = bus.mem_resp_fault; end
            tick();
        end
        check("t5_acc_load", {66'd0, acc_seen}, 68'd1);
        check("t5_pulses", 68'(npulse), 68'd1);
        check("t5_fault", {67'd0, fault_seen}, 68'd1);

        // Reset in the middle of a walk, then a stray PTW answer.
        fix_en = 1'b0; dly_lo = 6; dly_hi = 6;
        idle_cycles(2);
        bus.if_req_valid = 1'b1; bus.if_req_vaddr = 64'h5000;
        tick();
        bus.if_req_valid = 1'b0;
        lat = 0;
        for (int j = 0; j < 10 && lat == 0; j++) begin
            @(negedge clk);
            if (dbg_state == 2'd2) lat = 1;
            else tick();
        end
        check("t6_reached_wait", 68'(lat), 68'd1);
        tick();
        rst = 1'b0;
        tick();
        tick();
        @(negedge clk);
        check("t6_reset_outputs",
              {bus.ptw_req_valid, bus.if_resp_valid, bus.mem_resp_valid, bus.ptw_req_acc,
               bus.ptw_req_priv, dbg_state, bus.if_resp_fault, bus.mem_resp_fault, 57'd0},
              68'd0);
        check("t6_reset_paddr", {4'd0, bus.if_resp_paddr | bus.ptw_req_vaddr}, 68'd0);
        rst = 1'b1;
        tick();
        stray_cnt++;
        npulse = 0; lat = 0;
        for (int j = 0; j < 4; j++) begin
            tick();
            @(negedge clk);
            if (bus.if_resp_valid || bus.mem_resp_valid) npulse++;
            if (dbg_state != 2'd0) lat++;
        end
        check("t6_stray_ignored", 68'(npulse), 68'd0);
        check("t6_stays_idle", 68'(lat), 68'd0);
        dly_lo = 2; dly_hi = 2;
        tick();
        bus.if_req_valid = 1'b1; bus.if_req_vaddr = 64'h6000;
        @(negedge clk);
        check("t6_accept_after_reset", {67'd0, bus.if_req_ready}, 68'd1);
        tick();
        bus.if_req_valid = 1'b0;
        npulse = 0;
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            if (bus.if_resp_valid) npulse++;
            tick();
        end
        check("t6_walk_after_reset", 68'(npulse), 68'd1);

        // Random traffic against the model.
        rdy_pct = 70; dly_lo = 1; dly_hi = 4;
        for (int j = 0; j < 500; j++) begin
            bus.priv          = 2'($urandom_range(0, 3));
            bus.if_req_valid  = ($urandom_range(0, 1) == 1);
            bus.if_req_vaddr  = {$urandom, $urandom};
            bus.mem_req_valid = ($urandom_range(0, 1) == 1);
            bus.mem_req_vaddr = {$urandom, $urandom};
            bus.mem_req_we    = ($urandom_range(0, 1) == 1);
            bus.mem_req_re    = ($urandom_range(0, 1) == 1);
            bus.if_flush      = ($urandom_range(0, 7) == 0);
            bus.mem_flush     = ($urandom_range(0, 7) == 0);
            tick();
        end
        idle_cycles(30);
        check("drain_ptw_q", 68'(ptw_q.size()), 68'd0);
        check("drain_if_q", 68'(if_q.size()), 68'd0);
        check("drain_mem_q", 68'(mem_q.size()), 68'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
